data_mem_resp: RTL
==================

Name: data_mem_resp

Overview:
- Memory-side responder for the processor's load/store path.
- Accepts one word request at a time (address, write enable, write data) from the LOAD/STORE execution unit and services it against an internal word-addressed data array.
- Returns read data or a write acknowledge after a programmable latency, using a valid/ready response handshake.
- Sits between the memory execution unit and the data storage, completing the interface from the memory end.

Parameters:
- DATA_WIDTH, 32, word width; matches the package DATA_WIDTH.
- ADDR_WIDTH, 32, byte-address width of req_addr_i.
- DEPTH, 256, number of words in the array; power of two.
- RD_LATENCY, 2, cycles from request acceptance to rsp_valid_o; legal range 1..4.

Ports:
- clk_i  input  1  clock; all logic is rising-edge.
- rst_ni  input  1  synchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_we_i  input  1  1 = STORE, 0 = LOAD.
- req_wdata_i  input  DATA_WIDTH  store data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  requester accepts the response.
- rsp_rdata_o  output  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_err_o  output  1  request was misaligned or out of range.
- rsp_we_o  output  1  echoes req_we_i of the request being answered.

Behaviour:
- Reset: rst_ni sampled low at a clk_i edge forces:
  - state to IDLE, counter to 0;
  - req_ready_o=0 during reset, then 1 in the first IDLE cycle;
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_we_o=0.
  - Array contents are not reset.
- Reset mid-operation: any in-flight request is dropped with no response. A store already written at acceptance stays written.
- States:
  - IDLE: req_ready_o=1.
  - WAIT: latency counter running.
  - RESP: rsp_valid_o=1, outputs held stable.
- Acceptance: occurs on the edge where req_valid_i && req_ready_o. Address, we, wdata and the error flag are captured.
- Error detection: err = (req_addr_i[1:0] != 0) || (req_addr_i[ADDR_WIDTH-1:2] >= DEPTH).
- Word index: req_addr_i[$clog2(DEPTH)+1:2].
- Store: if not err, array[index] <= req_wdata_i on the acceptance edge. An erroring store writes nothing.
- Load: array read happens at acceptance and the result is captured. An erroring load returns data 0.
- Transitions:
  - IDLE -> RESP on acceptance when RD_LATENCY=1.
  - IDLE -> WAIT on acceptance when RD_LATENCY>1, counter loaded with RD_LATENCY-1.
  - WAIT: counter decrements each cycle; WAIT -> RESP on the edge where counter==1.
  - Result: rsp_valid_o rises exactly RD_LATENCY cycles after the acceptance edge.
- RESP: outputs hold until rsp_ready_i=1, then go to IDLE on that edge; rsp_valid_o drops the next cycle.
- No overlap: req_ready_o=0 in WAIT and RESP. Minimum spacing between acceptances is RD_LATENCY+1 cycles.
- rsp_ready_i asserted early (before RESP) has no effect.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored value.
- Signals are ignored outside acceptance: req_* changes while req_ready_o=0 have no effect.

Test Plan:
- Reset then idle: hold rst_ni=0 for 3 cycles, release -> all outputs 0 during reset; req_ready_o=1 the cycle after release; rsp_valid_o stays 0 with no request.
- Store then load, RD_LATENCY=2:
  - Store addr 0x10 data 0xDEADBEEF -> rsp_valid_o=1 two cycles after acceptance, rsp_we_o=1, rsp_err_o=0, rsp_rdata_o=0.
  - Load addr 0x10 -> rsp_rdata_o=0xDEADBEEF, rsp_we_o=0.
- Response backpressure: load addr 0x10 with rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rsp_rdata_o=0xDEADBEEF held stable and req_ready_o=0 throughout; IDLE one cycle after rsp_ready_i=1.
- Error cases:
  - Store addr 0x13 data 0x1234 -> rsp_err_o=1, array unchanged (load 0x10 still returns 0xDEADBEEF).
  - Load addr 4*DEPTH (0x400) -> rsp_err_o=1, rsp_rdata_o=0.
- Boundary word: store then load addr 0x3FC, data 0xA5A5A5A5 -> returns 0xA5A5A5A5, rsp_err_o=0; RD_LATENCY=1 build -> rsp_valid_o one cycle after acceptance.
- Reset mid-operation: accept load, pull rst_ni low during WAIT -> no response ever; after release req_ready_o=1 and a fresh load completes normally.

Source files
------------

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Memory-side responder for the load/store path. Accepts one
//               word request at a time and services it against an internal
//               word-addressed array. It returns load data or a store
//               acknowledge after RD_LATENCY cycles, using a valid/ready
//               response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_we_o
);

  localparam int IDX_W = $clog2(DEPTH);
  // Wide enough to hold RD_LATENCY-1 for the full 1..4 range
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_we_q, rsp_we_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      req_idx;
  logic                  req_err;
  logic                  accept;
  logic                  mem_wr;

  // Request decode: word index, misalignment/range error, acceptance, write strobe
  always_comb begin
    req_idx = req_addr_i[IDX_W+1:2];
    req_err = (req_addr_i[1:0] != 2'b00) ||
              (req_addr_i[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH));
    // Reset dominates: nothing is accepted while rst_ni is low
    accept  = req_valid_i && ready_q && rst_ni;
    mem_wr  = accept && req_we_i && !req_err;
  end

  // Next-state logic: capture on acceptance, count latency, hold until taken
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_we_d    = rsp_we_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // The array is read at acceptance; stores and errors report zero data
          rsp_rdata_d = (req_we_i || req_err) ? '0 : mem_q[req_idx];
          rsp_err_d   = req_err;
          rsp_we_d    = req_we_i;
          if (RD_LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags are registered decodes of the next state
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // Control and response registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Data array: written on the acceptance edge of a good store, never reset
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      mem_q[req_idx] <= req_wdata_i;
    end
  end

  // Ready is also masked combinationally so it reads low for the whole reset
  assign req_ready_o = ready_q && rst_ni;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_we_o    = rsp_we_q;

endmodule
`default_nettype wire
